// File: rtl/overlay_pkg.sv
// Shared types for the cross-marker overlay: RGB565 field layout, default raster size, centre config.
// Latency: none (types, constants and pure functions only).
// Backpressure: none.
package overlay_pkg;

  // RGB565 layout {R[15:11], G[10:5], B[4:0]}
  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int R_LSB = 11;
  localparam int G_LSB = 5;
  localparam int B_LSB = 0;

  // Default panel raster
  localparam int H_ACTIVE_DEF = 480;
  localparam int V_ACTIVE_DEF = 272;

  // Centre coordinates are held at a fixed width wide enough for any supported raster;
  // narrower port values are zero-extended on capture.
  localparam int COORD_W = 10;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               en;
  } cfg_t;

  localparam cfg_t CFG_RST = '{x: '0, y: '0, en: 1'b0};

  typedef enum logic {
    CFG_IDLE = 1'b0,
    CFG_PEND = 1'b1
  } cfg_state_t;

  function automatic logic [R_W-1:0] rgb_r(input logic [15:0] p);
    return p[R_LSB +: R_W];
  endfunction

  function automatic logic [G_W-1:0] rgb_g(input logic [15:0] p);
    return p[G_LSB +: G_W];
  endfunction

  function automatic logic [B_W-1:0] rgb_b(input logic [15:0] p);
    return p[B_LSB +: B_W];
  endfunction

endpackage

// File: rtl/overlay_px_cnt.sv
// Raster position tracker: DE/VSYNC edge detect plus saturating x/y pixel counters.
// Latency: x/y describe the pixel currently on the input; de_d/vs_d are the inputs delayed 1 cycle.
// Backpressure: none, follows the free-running pixel stream.
module overlay_px_cnt #(
  parameter int H_ACTIVE = 480,
  parameter int V_ACTIVE = 272,
  parameter int XW = $clog2(H_ACTIVE),
  parameter int YW = $clog2(V_ACTIVE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          de,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          vs_rise,
  output logic          de_d,
  output logic          vs_d
);

  localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE - 1);

  logic de_fall;

  assign vs_rise = vsync & ~vs_d;
  assign de_fall = ~de & de_d;

  // Edge-detect history; doubles as the 1-cycle DE/VSYNC delay seen downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_d <= 1'b0;
      vs_d <= 1'b0;
    end else begin
      de_d <= de;
      vs_d <= vsync;
    end
  end

  // Pixel/line counters: frame start wins, then end of line, then pixel advance; both hold at max
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (vs_rise) begin
      x <= '0;
      y <= '0;
    end else if (de_fall) begin
      x <= '0;
      if (y != Y_MAX) y <= y + 1'b1;
    end else if (de && (x != X_MAX)) begin
      x <= x + 1'b1;
    end
  end

endmodule

// File: rtl/overlay_cross_ctrl.sv
// Cross-marker select for the RGB565 force-colour mux; optional blink with OVERLAY_BLINK_EN.
// Latency: 1 cycle from PIX_IN/DE/VSYNC to PIX_*/DE_O/VSYNC_O/SEL, all mutually aligned.
// Backpressure: CFG_READY drops once a centre is pending and rises after the next frame start.
module overlay_cross_ctrl
  import overlay_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ARM_LEN  = 8,
  parameter int ARM_W    = 1,
`ifdef OVERLAY_BLINK_EN
  parameter int BLINK_LOG2 = 5,
`endif
  parameter int XW = $clog2(H_ACTIVE),
  parameter int YW = $clog2(V_ACTIVE)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          VSYNC,
  input  logic          DE,
  input  logic [15:0]   PIX_IN,
  input  logic          CFG_VALID,
  output logic          CFG_READY,
  input  logic [XW-1:0] CFG_X,
  input  logic [YW-1:0] CFG_Y,
  input  logic          CFG_EN,
  output logic [4:0]    PIX_R,
  output logic [5:0]    PIX_G,
  output logic [4:0]    PIX_B,
  output logic          DE_O,
  output logic          VSYNC_O,
  output logic          SEL
);

  localparam logic [COORD_W:0] LEN = (COORD_W+1)'(ARM_LEN);
  localparam logic [COORD_W:0] WID = (COORD_W+1)'(ARM_W);

  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic          vs_rise;

  overlay_px_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .XW       (XW),
    .YW       (YW)
  ) u_px_cnt (
    .clk     (CLK),
    .rst     (RST),
    .vsync   (VSYNC),
    .de      (DE),
    .x       (px),
    .y       (py),
    .vs_rise (vs_rise),
    .de_d    (DE_O),
    .vs_d    (VSYNC_O)
  );

  // ---------------- centre configuration ----------------
  cfg_state_t state, state_nxt;
  logic       cap, apply;
  cfg_t       pend_cfg, act_cfg;

  // Config handshake state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= CFG_IDLE;
    else     state <= state_nxt;
  end

  // One centre may be pending; it is promoted only at a frame start so a frame never changes mid-way
  always_comb begin
    state_nxt = state;
    CFG_READY = 1'b0;
    cap       = 1'b0;
    apply     = 1'b0;
    case (state)
      CFG_IDLE: begin
        CFG_READY = 1'b1;
        if (CFG_VALID) begin
          cap       = 1'b1;
          state_nxt = CFG_PEND;
        end
      end
      CFG_PEND: begin
        if (vs_rise) begin
          apply     = 1'b1;
          state_nxt = CFG_IDLE;
        end
      end
      default: state_nxt = CFG_IDLE;
    endcase
  end

  // Pending and active centre shadow registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_cfg <= CFG_RST;
      act_cfg  <= CFG_RST;
    end else begin
      if (cap) begin
        pend_cfg.x  <= COORD_W'(CFG_X);
        pend_cfg.y  <= COORD_W'(CFG_Y);
        pend_cfg.en <= CFG_EN;
      end
      if (apply) act_cfg <= pend_cfg;
    end
  end

  // ---------------- optional blink ----------------
  logic blink_on;
`ifdef OVERLAY_BLINK_EN
  logic [BLINK_LOG2:0] frame_cnt;

  // Frame counter; its MSB splits the blink period into visible and hidden halves
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          frame_cnt <= '0;
    else if (vs_rise) frame_cnt <= frame_cnt + 1'b1;
  end

  assign blink_on = ~frame_cnt[BLINK_LOG2];
`else
  assign blink_on = 1'b1;
`endif

  // ---------------- hit test ----------------
  // One extra sign bit keeps differences exact, so centres near an edge clip instead of wrapping.
  logic signed [COORD_W:0] dx, dy;
  logic        [COORD_W:0] adx, ady;
  logic                    in_h, in_v, hit;

  // Signed distance from centre and the two bar membership tests
  always_comb begin
    dx   = $signed({1'b0, COORD_W'(px)}) - $signed({1'b0, act_cfg.x});
    dy   = $signed({1'b0, COORD_W'(py)}) - $signed({1'b0, act_cfg.y});
    adx  = dx[COORD_W] ? $unsigned(-dx) : $unsigned(dx);
    ady  = dy[COORD_W] ? $unsigned(-dy) : $unsigned(dy);
    in_h = (ady <= WID) && (adx <= LEN);
    in_v = (adx <= WID) && (ady <= LEN);
    hit  = DE & act_cfg.en & blink_on & (in_h | in_v);
  end

  // Output pipe: select and split colour fields stay aligned with DE_O/VSYNC_O
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SEL   <= 1'b0;
      PIX_R <= '0;
      PIX_G <= '0;
      PIX_B <= '0;
    end else begin
      SEL   <= hit;
      PIX_R <= rgb_r(PIX_IN);
      PIX_G <= rgb_g(PIX_IN);
      PIX_B <= rgb_b(PIX_IN);
    end
  end

endmodule
